// File: rtl/soc_cpu_oci_pkg.sv
// Shared OCI trace definitions: direct-compressed-trace code values, the
// packer sequencing states and the default trace-word width.
package soc_cpu_oci_pkg;

  localparam logic [1:0] DCT_SEQ    = 2'b00;
  localparam logic [1:0] DCT_TAKEN  = 2'b01;
  localparam logic [1:0] DCT_NTAKEN = 2'b10;
  localparam logic [1:0] DCT_EXC    = 2'b11;

  // {count(4), pad(2), buffer(15 codes x 2 bits)}
  localparam int unsigned TW_W = 36;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DONE
  } dct_state_e;

endpackage

// File: rtl/soc_cpu_oci_dct_packer_if.sv
// Trace-side handshakes of the DCT packer.
//   itrace_valid/itrace_code/itrace_ready : per-instruction code stream in
//   tw_valid/tw_data/tw_ready             : packed trace words out to the FIFO
// master: the surrounding system (code source and FIFO sink).
// slave : the packer.
interface soc_cpu_oci_dct_packer_if
  import soc_cpu_oci_pkg::*;
#(
  parameter int unsigned FRAG_W = 2,
  parameter int unsigned TW_W   = soc_cpu_oci_pkg::TW_W
);
  logic              itrace_valid;
  logic [FRAG_W-1:0] itrace_code;
  logic              itrace_ready;
  logic              tw_valid;
  logic [TW_W-1:0]   tw_data;
  logic              tw_ready;

  modport master (
    output itrace_valid, itrace_code, tw_ready,
    input  itrace_ready, tw_valid, tw_data
  );

  modport slave (
    input  itrace_valid, itrace_code, tw_ready,
    output itrace_ready, tw_valid, tw_data
  );
endinterface

// File: rtl/soc_cpu_oci_tw_slot.sv
// Single-entry valid/ready output register for trace words.
//   load/load_data : capture a new word (only issued while free=1)
//   out_valid/out_data/out_ready : downstream handshake; data held while stalled
//   free           : slot empty now, or emptying on this cycle's handshake
module soc_cpu_oci_tw_slot #(
  parameter int unsigned W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         free
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/soc_cpu_oci_dct_packer.sv
// Packs 2-bit direct-compressed-trace codes into trace words
// {dct_count, 2'b00, dct_buffer}; oldest code sits in the buffer MSBs.
//   clk, reset_n    : clock, async active-low reset
//   trc_ctrl_en     : trace enable; codes ignored while low
//   flush_req       : pulse requesting emission of a partial word
//   flush_done      : one-cycle pulse when a flush completes
//   bus             : code input and trace-word output handshakes
//   dct_buffer/count: live packing register and its fill level
module soc_cpu_oci_dct_packer
  import soc_cpu_oci_pkg::*;
#(
  parameter int unsigned FRAG_W = 2,
  parameter int unsigned DEPTH  = 15,
  parameter int unsigned CNT_W  = 4,
  localparam int unsigned BUF_W = FRAG_W * DEPTH,
  localparam int unsigned TW_W  = CNT_W + 2 + BUF_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     trc_ctrl_en,
  input  logic                     flush_req,
  output logic                     flush_done,
  soc_cpu_oci_dct_packer_if.slave  bus,
  output logic [BUF_W-1:0]         dct_buffer,
  output logic [CNT_W-1:0]         dct_count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  dct_state_e state;
  logic       full;
  logic       slot_free;
  logic       accept;
  logic       emit;

  assign full   = (dct_count == DEPTH_C);
  // slot_free already folds in "tw_valid & tw_ready this cycle"
  assign bus.itrace_ready = (state == RUN) && !(full && !slot_free);
  assign accept = trc_ctrl_en && bus.itrace_valid && bus.itrace_ready;
  assign emit   = slot_free && (full || (state == FLUSH && dct_count != '0));

  soc_cpu_oci_tw_slot #(.W(TW_W)) u_slot (
    .clk       (clk),
    .rst_n     (reset_n),
    .load      (emit),
    .load_data ({dct_count, 2'b00, dct_buffer}),
    .out_ready (bus.tw_ready),
    .out_valid (bus.tw_valid),
    .out_data  (bus.tw_data),
    .free      (slot_free)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_done <= 1'b0;
    end else begin
      // An accept coinciding with an emit starts the fresh word with that code.
      if (emit) begin
        dct_buffer <= accept ? BUF_W'(bus.itrace_code) : '0;
        dct_count  <= accept ? CNT_W'(1) : '0;
      end else if (accept) begin
        dct_buffer <= {dct_buffer[BUF_W-FRAG_W-1:0], bus.itrace_code};
        dct_count  <= dct_count + CNT_W'(1);
      end

      // A partial flush emits first; the emptied count then routes FLUSH to DONE,
      // so flush_done trails the flushed word by one cycle.
      case (state)
        RUN: begin
          flush_done <= 1'b0;
          if (flush_req) state <= FLUSH;
        end
        FLUSH: begin
          if (dct_count == '0) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_cpu_oci_dct_packer.sv
module tb_soc_cpu_oci_dct_packer;
  import soc_cpu_oci_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        trc_ctrl_en = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  int total = 0;
  int bad   = 0;

  soc_cpu_oci_dct_packer_if #(.FRAG_W(2), .TW_W(36)) bus ();

  soc_cpu_oci_dct_packer #(.FRAG_W(2), .DEPTH(15), .CNT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_ctrl_en (trc_ctrl_en),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .bus         (bus.slave),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    bus.itrace_valid = 1'b1;
    bus.itrace_code  = c;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.itrace_valid = 1'b0;
    bus.itrace_code  = '0;
    bus.tw_ready     = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_tw_valid", 64'(bus.tw_valid), 64'd0);
    check("rst_tw_data", 64'(bus.tw_data), 64'd0);
    check("rst_count", 64'(dct_count), 64'd0);
    check("rst_buffer", 64'(dct_buffer), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_ready", 64'(bus.itrace_ready), 64'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Fill: 15 taken codes
    trc_ctrl_en  = 1'b1;
    bus.tw_ready = 1'b1;
    repeat (15) send(DCT_TAKEN);
    bus.itrace_valid = 1'b0;
    check("fill_count15", 64'(dct_count), 64'd15);
    check("fill_buffer", 64'(dct_buffer), 64'h1555_5555);
    check("fill_pre_valid", 64'(bus.tw_valid), 64'd0);
    tick();
    check("fill_valid", 64'(bus.tw_valid), 64'd1);
    check("fill_data", 64'(bus.tw_data), 64'hF_1555_5555);
    check("fill_count0", 64'(dct_count), 64'd0);
    tick();
    check("fill_drain", 64'(bus.tw_valid), 64'd0);

    // Backpressure: 30 accepts with the FIFO stalled
    bus.tw_ready = 1'b0;
    repeat (15) send(DCT_NTAKEN);
    send(DCT_EXC);
    check("bp_valid1", 64'(bus.tw_valid), 64'd1);
    check("bp_data1", 64'(bus.tw_data), 64'hF_2AAA_AAAA);
    check("bp_count1", 64'(dct_count), 64'd1);
    check("bp_buffer1", 64'(dct_buffer), 64'd3);
    repeat (14) send(DCT_EXC);
    bus.itrace_valid = 1'b0;
    check("bp_count15", 64'(dct_count), 64'd15);
    check("bp_ready0", 64'(bus.itrace_ready), 64'd0);
    tick();
    check("bp_hold", 64'(bus.tw_data), 64'hF_2AAA_AAAA);
    check("bp_hold_valid", 64'(bus.tw_valid), 64'd1);
    bus.tw_ready = 1'b1;
    #1;
    check("bp_ready1", 64'(bus.itrace_ready), 64'd1);
    tick();
    check("bp_valid2", 64'(bus.tw_valid), 64'd1);
    check("bp_data2", 64'(bus.tw_data), 64'hF_3FFF_FFFF);
    check("bp_count0", 64'(dct_count), 64'd0);
    tick();
    check("bp_drain", 64'(bus.tw_valid), 64'd0);

    // Partial flush with an enable-low hold in the middle
    send(DCT_EXC);
    trc_ctrl_en      = 1'b0;
    bus.itrace_valid = 1'b1;
    bus.itrace_code  = DCT_SEQ;
    tick();
    check("en_hold", 64'(dct_count), 64'd1);
    trc_ctrl_en = 1'b1;
    send(DCT_NTAKEN);
    send(DCT_TAKEN);
    bus.itrace_valid = 1'b0;
    check("pf_buffer", 64'(dct_buffer), 64'h39);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("pf_ready0", 64'(bus.itrace_ready), 64'd0);
    check("pf_no_valid", 64'(bus.tw_valid), 64'd0);
    tick();
    check("pf_valid", 64'(bus.tw_valid), 64'd1);
    check("pf_data", 64'(bus.tw_data), 64'h3_0000_0039);
    check("pf_done_early", 64'(flush_done), 64'd0);
    check("pf_count0", 64'(dct_count), 64'd0);
    tick();
    check("pf_done", 64'(flush_done), 64'd1);
    tick();
    check("pf_done_off", 64'(flush_done), 64'd0);
    check("pf_ready1", 64'(bus.itrace_ready), 64'd1);

    // Empty flush
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("ef_done_early", 64'(flush_done), 64'd0);
    tick();
    check("ef_done", 64'(flush_done), 64'd1);
    check("ef_no_valid", 64'(bus.tw_valid), 64'd0);
    tick();
    check("ef_done_off", 64'(flush_done), 64'd0);

    // Simultaneous: slot frees on the cycle of the 16th accept
    bus.tw_ready = 1'b0;
    send(DCT_TAKEN);
    bus.itrace_valid = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    check("sim_pword", 64'(bus.tw_data), 64'h1_0000_0001);
    tick();
    tick();
    repeat (15) send(DCT_NTAKEN);
    bus.itrace_valid = 1'b1;
    bus.itrace_code  = DCT_EXC;
    tick();
    check("sim_blocked", 64'(dct_count), 64'd15);
    bus.tw_ready = 1'b1;
    tick();
    bus.itrace_valid = 1'b0;
    bus.tw_ready     = 1'b0;
    check("sim_count1", 64'(dct_count), 64'd1);
    check("sim_buffer", 64'(dct_buffer), 64'd3);
    check("sim_data", 64'(bus.tw_data), 64'hF_2AAA_AAAA);
    check("sim_valid", 64'(bus.tw_valid), 64'd1);

    // Reset mid-fill with a word stuck in the slot
    repeat (6) send(DCT_SEQ);
    bus.itrace_valid = 1'b0;
    check("rm_count7", 64'(dct_count), 64'd7);
    #2 reset_n = 1'b0;
    #1;
    check("rm_tw_valid", 64'(bus.tw_valid), 64'd0);
    check("rm_tw_data", 64'(bus.tw_data), 64'd0);
    check("rm_count", 64'(dct_count), 64'd0);
    check("rm_buffer", 64'(dct_buffer), 64'd0);
    check("rm_flush_done", 64'(flush_done), 64'd0);
    #2 reset_n = 1'b1;
    #1;
    check("rm_ready", 64'(bus.itrace_ready), 64'd1);
    tick();
    check("rm_post_count", 64'(dct_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
